// File: rtl/block_sync_pkg.sv
// Shared definitions for 64b/66b block synchronisation: header width,
// default lock thresholds, the lock FSM state type and header classification.
package block_sync_pkg;

  localparam int HDR_WIDTH       = 2;
  localparam int DEF_LOCK_CNT    = 64;
  localparam int DEF_INVALID_MAX = 16;
  localparam int DEF_SLIP_WAIT   = 4;
  // Number of headers in one invalid-count window while locked.
  localparam int WINDOW_LEN      = 64;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP      = 2'd1,
    ST_SLIP_WAIT = 2'd2,
    ST_LOCKED    = 2'd3
  } lock_state_t;

  // Only 01 and 10 are legal 66b sync headers; 00 and 11 mean misalignment.
  function automatic logic hdr_is_valid(input logic [HDR_WIDTH-1:0] hdr);
    return (hdr == 2'b01) || (hdr == 2'b10);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// Receive block-lock state machine: hunts for LOCK_CNT consecutive valid sync
// headers, requests single-bit slips from the gearbox on misalignment, and
// drops lock when INVALID_MAX bad headers land inside one 64-header window.
module rx_block_lock
  import block_sync_pkg::*;
#(
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int INVALID_MAX = DEF_INVALID_MAX,
  parameter int SLIP_WAIT   = DEF_SLIP_WAIT
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [HDR_WIDTH-1:0] i_sync_hdr,
  input  logic                 i_hdr_valid,
  output logic                 o_slip,
  output logic                 o_block_lock,
  output logic [4:0]           o_invalid_cnt,
  output logic [15:0]          o_slip_cnt
);

  // The header counter serves both the hunt run length and the locked window.
  localparam int SH_MAX = (LOCK_CNT > WINDOW_LEN) ? LOCK_CNT : WINDOW_LEN;
  localparam int SH_W   = $clog2(SH_MAX + 1);
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  lock_state_t       state, state_nxt;
  logic [SH_W-1:0]   sh_cnt, sh_nxt, sh_inc;
  logic [4:0]        inv_cnt, inv_nxt, inv_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [15:0]       slip_cnt, slip_cnt_nxt;
  logic              hdr_ok;

  // Saturating increment for the slip statistics counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign hdr_ok  = hdr_is_valid(i_sync_hdr);
  assign sh_inc  = sh_cnt + 1'b1;
  assign inv_inc = inv_cnt + 5'd1;

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= ST_HUNT;
      sh_cnt   <= '0;
      inv_cnt  <= '0;
      wait_cnt <= '0;
      slip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sh_cnt   <= sh_nxt;
      inv_cnt  <= inv_nxt;
      wait_cnt <= wait_nxt;
      slip_cnt <= slip_cnt_nxt;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_nxt    = state;
    sh_nxt       = sh_cnt;
    inv_nxt      = inv_cnt;
    wait_nxt     = wait_cnt;
    slip_cnt_nxt = slip_cnt;
    unique case (state)
      ST_HUNT: begin
        if (i_hdr_valid) begin
          if (hdr_ok) begin
            if (sh_inc == SH_W'(LOCK_CNT)) begin
              state_nxt = ST_LOCKED;
              sh_nxt    = '0;
              inv_nxt   = '0;
            end else begin
              sh_nxt = sh_inc;
            end
          end else begin
            // Counted as a slip when the pulse is issued.
            state_nxt    = ST_SLIP;
            sh_nxt       = '0;
            inv_nxt      = '0;
            slip_cnt_nxt = sat_inc16(slip_cnt);
          end
        end
      end
      ST_SLIP: begin
        state_nxt = ST_SLIP_WAIT;
        wait_nxt  = '0;
      end
      ST_SLIP_WAIT: begin
        // Headers are ignored while the gearbox realigns.
        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          state_nxt = ST_HUNT;
          sh_nxt    = '0;
          inv_nxt   = '0;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (i_hdr_valid) begin
          // Loss of lock is checked before the window wrap so it wins a tie.
          if (!hdr_ok && (inv_inc == 5'(INVALID_MAX))) begin
            state_nxt    = ST_SLIP;
            sh_nxt       = '0;
            inv_nxt      = '0;
            slip_cnt_nxt = sat_inc16(slip_cnt);
          end else if (sh_inc == SH_W'(WINDOW_LEN)) begin
            sh_nxt  = '0;
            inv_nxt = '0;
          end else begin
            sh_nxt  = sh_inc;
            inv_nxt = hdr_ok ? inv_cnt : inv_inc;
          end
        end
      end
      default: begin
        state_nxt = ST_HUNT;
        sh_nxt    = '0;
        inv_nxt   = '0;
        wait_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded straight from registered state, so they move one
  // cycle after the triggering header.
  assign o_slip        = (state == ST_SLIP);
  assign o_block_lock  = (state == ST_LOCKED);
  assign o_invalid_cnt = (state == ST_LOCKED) ? inv_cnt : 5'd0;
  assign o_slip_cnt    = slip_cnt;

endmodule

// File: doc/rx_block_lock.md
RX_BLOCK_LOCK -- requirements
Module: rx_block_lock

Interface
REQ-001 Parameter HDR_WIDTH, 2, sync header width in bits.
REQ-002 Parameter LOCK_CNT, 64, consecutive valid headers required to declare lock.
REQ-003 Parameter INVALID_MAX, 16, invalid headers per 64-block window that force loss of lock.
REQ-004 Parameter SLIP_WAIT, 4, cycles during which headers are ignored after each slip pulse.
REQ-005 i_clk  input  1  single clock; all logic rising-edge.
REQ-006 i_reset_n  input  1  synchronous, active-low reset.
REQ-007 i_sync_hdr  input  HDR_WIDTH  sync header of the current 66b block from the gearbox.
REQ-008 i_hdr_valid  input  1  qualifies i_sync_hdr; at most one header per cycle; gaps allowed.
REQ-009 o_slip  output  1  one-cycle pulse telling the gearbox to shift alignment by one bit.
REQ-010 o_block_lock  output  1  high while block alignment is locked.
REQ-011 o_invalid_cnt  output  5  invalid-header count in the current locked window.
REQ-012 o_slip_cnt  output  16  total slips since reset, saturating at 0xFFFF.

Function
REQ-013 A header SHALL be valid when it is 2'b01 or 2'b10 and invalid when it is 2'b00 or 2'b11; headers are sampled only when i_hdr_valid=1.
REQ-014 The FSM SHALL have four states: HUNT, SLIP, SLIP_WAIT and LOCKED.
REQ-015 In HUNT, a valid header SHALL increment sh_cnt; the valid header that makes the count reach LOCK_CNT SHALL move the FSM to LOCKED and clear both counters.
REQ-016 In HUNT, an invalid header SHALL move the FSM to SLIP and clear sh_cnt.
REQ-017 In SLIP, o_slip SHALL be 1 for exactly one cycle; the FSM SHALL then enter SLIP_WAIT, and o_slip_cnt SHALL increment unless it is already 0xFFFF.
REQ-018 In SLIP_WAIT, i_hdr_valid SHALL be ignored for SLIP_WAIT cycles; the FSM SHALL then return to HUNT with both counters at zero.
REQ-019 In LOCKED, every sampled header SHALL increment sh_cnt, and every invalid header SHALL also increment the invalid count.
REQ-020 In LOCKED, the invalid header that brings the invalid count to INVALID_MAX SHALL move the FSM to SLIP, clear o_block_lock and clear both counters.
REQ-021 In LOCKED, when the 64th header of a window is sampled and the invalid count stays below INVALID_MAX, both counters SHALL clear and the FSM SHALL stay in LOCKED.
REQ-022 When the 16th invalid header is also the 64th header of the window, loss of lock SHALL take priority over the window reset.
REQ-023 All outputs SHALL be registered; o_block_lock and o_slip SHALL change in the cycle after the header that triggers them is sampled, giving a latency of one cycle.
REQ-024 o_invalid_cnt SHALL reflect the registered invalid count and SHALL read 0 whenever the FSM is outside LOCKED.
REQ-025 The minimum spacing between two o_slip pulses SHALL be 2+SLIP_WAIT cycles.

Reset
REQ-026 When i_reset_n=0 at a clock edge, the FSM SHALL go to HUNT and o_slip, o_block_lock, o_invalid_cnt, o_slip_cnt and sh_cnt SHALL all go to 0.
REQ-027 A reset asserted mid-operation, including during SLIP or SLIP_WAIT, SHALL abort immediately, with no slip pulse in the cycle after reset.

Structure
REQ-028 HDR_WIDTH, the LOCK_CNT, INVALID_MAX and SLIP_WAIT defaults, and the lock_state_t state enum SHALL reside in the shared block_sync_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the counters and the FSM are inline.

Verification
REQ-030 Drive 64 consecutive valid headers (alternating 01/10) after reset -> o_block_lock=1 one cycle after the 64th header, with o_slip never asserted.
REQ-031 Drive 10 valid headers, then one 2'b11 in HUNT -> exactly one o_slip pulse, headers ignored for 4 cycles, o_slip_cnt=1, and lock reached only after 64 further valid headers.
REQ-032 While locked, drive 15 invalid headers within one 64-header window -> lock held, o_invalid_cnt=15, and the count clears to 0 after the 64th header.
REQ-033 While locked, place the 16th invalid header as the 64th header of a window -> o_block_lock=0 and one o_slip pulse on the next cycle.
REQ-034 Assert i_reset_n=0 during SLIP_WAIT -> all outputs 0 on the next cycle, state HUNT, and no slip pulse.
REQ-035 Force o_slip_cnt to 0xFFFF, then trigger another slip -> o_slip_cnt stays at 0xFFFF.
